intt_stage_controller: RTL

- Sequences one full inverse-NTT pass (N = 2^LOG_N coefficients) across the core array and the INTT router.
- Per stage it drives log_m/log_t and issues read address pairs to the coefficient BRAMs, then inserts a drain gap so loop-back writes land before the next stage reads.
- Controls the start/busy/done handshake with the host-side loader, and honours a stall from the output sink.
- Sits between the top-level control FSM and the intt_router/core/BRAM datapath.

---
 rtl/intt_stage_controller.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/intt_stage_controller.sv
// Inverse-NTT pass sequencer: walks LOG_N stages of read-pair issue plus pipeline drain.
// Optional INTT_STAGE_CTRL_PERF_EN adds saturating cycle_count/stall_count outputs.
module intt_stage_controller #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_N          = 12,
    parameter int PIPE_LATENCY   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic [3:0] log_m,
    output logic [3:0] log_t,
    output logic       rd_en,
    output logic [8:0] rd_addr [1:0],
    output logic [3:0] stage_idx,
    output logic       last_stage
`ifdef INTT_STAGE_CTRL_PERF_EN
    ,
    output logic [15:0] cycle_count,
    output logic [15:0] stall_count
`endif
);

    // state  | meaning
    // IDLE   | waiting for start, outputs at reset values
    // ISSUE  | presenting read-address pairs for the current stage
    // DRAIN  | waiting PIPE_LATENCY unstalled cycles for loop-back writes
    // DONE   | one-cycle done pulse, busy still high

    localparam int WORDS     = 2 ** (LOG_N - LOG_CORE_COUNT - 2);
    localparam int ISSUE_LEN = WORDS / 2;

    localparam logic [8:0] LAST_PAIR  = 9'(ISSUE_LEN - 1);
    localparam logic [3:0] LAST_STAGE = 4'(LOG_N - 1);
    localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_LATENCY - 1);

    if (LOG_CORE_COUNT < 0 || LOG_CORE_COUNT > 8) begin : g_bad_core_count
        $error("intt_stage_controller: LOG_CORE_COUNT must be within 0..8");
    end
    if (PIPE_LATENCY < 1 || PIPE_LATENCY > 255) begin : g_bad_latency
        $error("intt_stage_controller: PIPE_LATENCY must be within 1..255");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t     state, state_d;
    logic [8:0] pair_q, pair_d;
    logic [7:0] drain_q, drain_d;
    logic [3:0] stage_d;
    logic       busy_d, done_d, rd_en_d;
    logic [8:0] addr0_d, addr1_d;
    logic [3:0] log_m_d, log_t_d;
    logic       last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Everything below is the registered image of what the next cycle presents,
    // so stall sampled at an edge shapes the following cycle.
    always_comb begin
        state_d = state;
        busy_d  = busy;
        done_d  = 1'b0;
        rd_en_d = 1'b0;
        pair_d  = pair_q;
        drain_d = drain_q;
        stage_d = stage_idx;
        addr0_d = rd_addr[0];
        addr1_d = rd_addr[1];

        case (state)
            IDLE: begin
                addr0_d = '0;
                addr1_d = '0;
                if (start) begin
                    state_d = ISSUE;
                    busy_d  = 1'b1;
                    stage_d = '0;
                    pair_d  = '0;
                    rd_en_d = 1'b1;
                    addr1_d = 9'd1;
                end
            end
            ISSUE: begin
                if (rd_en && pair_q == LAST_PAIR) begin
                    state_d = DRAIN;
                    pair_d  = '0;
                    drain_d = DRAIN_LOAD;
                end else begin
                    if (rd_en) begin
                        pair_d = pair_q + 9'd1;
                    end
                    rd_en_d = !stall;
                    addr0_d = {pair_d[7:0], 1'b0};
                    addr1_d = {pair_d[7:0], 1'b1};
                end
            end
            DRAIN: begin
                if (!stall) begin
                    if (drain_q == 8'd0) begin
                        if (stage_idx == LAST_STAGE) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ISSUE;
                            stage_d = stage_idx + 4'd1;
                            pair_d  = '0;
                            rd_en_d = 1'b1;
                            addr0_d = 9'd0;
                            addr1_d = 9'd1;
                        end
                    end else begin
                        drain_d = drain_q - 8'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                stage_d = '0;
                addr0_d = '0;
                addr1_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        log_m_d = 4'(LOG_N) - stage_d;
        log_t_d = stage_d;
        last_d  = (log_m_d == 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q     <= '0;
            drain_q    <= '0;
            stage_idx  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr[0] <= '0;
            rd_addr[1] <= '0;
            log_m      <= 4'(LOG_N);
            log_t      <= '0;
            last_stage <= 1'b0;
        end else begin
            pair_q     <= pair_d;
            drain_q    <= drain_d;
            stage_idx  <= stage_d;
            busy       <= busy_d;
            done       <= done_d;
            rd_en      <= rd_en_d;
            rd_addr[0] <= addr0_d;
            rd_addr[1] <= addr1_d;
            log_m      <= log_m_d;
            log_t      <= log_t_d;
            last_stage <= last_d;
        end
    end

`ifdef INTT_STAGE_CTRL_PERF_EN
    // cycle_count shows busy cycles up to and including the current one, hence the load of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else if (state == IDLE && start) begin
            cycle_count <= 16'd1;
            stall_count <= '0;
        end else begin
            if (busy && state != DONE && cycle_count != 16'hFFFF) begin
                cycle_count <= cycle_count + 16'd1;
            end
            if (busy && stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule
